// File: rtl/pipeline_hazard_controller.sv
// Load-use stall and data-memory freeze scheduler for the 5-stage pipeline.
// Tracks the EX/MEM occupants and keeps saturating stall/freeze counters.
module pipeline_hazard_controller #(
  parameter int          CNT_W    = 8,
  parameter logic [5:0]  LOAD_OP  = 6'b010100,
  parameter logic [5:0]  STORE_OP = 6'b010101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ins,
  input  logic             ins_valid,
  input  logic             dm_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_bubble,
  output logic             pipe_en,
  output logic [1:0]       hazard_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } hz_e;

  logic [5:0] op;
  logic [4:0] rw;
  logic [4:0] ra;
  logic [4:0] rb;
  logic       unused;

  assign op     = ins[31:26];
  assign rw     = ins[25:21];
  assign ra     = ins[20:16];
  assign rb     = ins[15:11];
  assign unused = ^ins[10:0];

  logic rd_ra;
  logic rd_rb;
  logic rd_rw;
  logic is_ld;
  logic is_mem;

  logic       ex_valid;
  logic       ex_is_load;
  logic       ex_is_mem;
  logic [4:0] ex_rw;
  logic       mem_valid;
  logic       mem_is_mem;

  logic load_use;
  logic mem_wait;
  logic hit;
  hz_e  state;

  // Decode which registers the ID instruction reads.
  always_comb begin
    rd_ra  = 1'b0;
    rd_rb  = 1'b0;
    rd_rw  = 1'b0;
    is_ld  = 1'b0;
    is_mem = 1'b0;
    unique case (1'b1)
      (op[5:3] == 3'b000): begin
        rd_ra = 1'b1;
        rd_rb = 1'b1;
      end
      (op[5:3] == 3'b001): begin
        rd_ra = 1'b1;
      end
      (op == LOAD_OP): begin
        rd_ra  = 1'b1;
        is_ld  = 1'b1;
        is_mem = 1'b1;
      end
      (op == STORE_OP): begin
        rd_ra  = 1'b1;
        rd_rw  = 1'b1;
        is_mem = 1'b1;
      end
      default: ;
    endcase
  end

  assign hit = (rd_ra && (ra == ex_rw))
            || (rd_rb && (rb == ex_rw))
            || (rd_rw && (rw == ex_rw));

  assign load_use = ins_valid && ex_valid && ex_is_load
                 && (ex_rw != 5'd0) && hit;

  assign mem_wait = mem_valid && mem_is_mem && !dm_ready;

  // Resolve the hazard class; memory wait outranks a load-use bubble.
  always_comb begin
    state       = RUN;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    pipe_en     = 1'b0;
    idex_bubble = 1'b0;
    if (!reset) begin
      state = RUN;
    end else if (mem_wait) begin
      state = MEM_WAIT;
    end else if (load_use) begin
      state       = LOAD_STALL;
      pipe_en     = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      state   = RUN;
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      pipe_en = 1'b1;
    end
  end

  assign hazard_state = state;

  // Advance the EX/MEM shadow slots whenever the pipe moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_is_mem  <= 1'b0;
      ex_rw      <= 5'd0;
      mem_valid  <= 1'b0;
      mem_is_mem <= 1'b0;
    end else if (pipe_en) begin
      mem_valid  <= ex_valid;
      mem_is_mem <= ex_is_mem;
      if (idex_bubble || !ins_valid) begin
        ex_valid   <= 1'b0;
        ex_is_load <= 1'b0;
        ex_is_mem  <= 1'b0;
        ex_rw      <= 5'd0;
      end else begin
        ex_valid   <= 1'b1;
        ex_is_load <= is_ld;
        ex_is_mem  <= is_mem;
        ex_rw      <= rw;
      end
    end
  end

  // Saturating counts of bubbles and frozen cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (state == LOAD_STALL && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (state == MEM_WAIT && freeze_cnt != '1)
        freeze_cnt <= freeze_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller.
// Expected per-cycle controls are queued at drive time, checked mid-cycle.
module tb_pipeline_hazard_controller;

  localparam logic [1:0] S_RUN = 2'b00;
  localparam logic [1:0] S_LS  = 2'b01;
  localparam logic [1:0] S_MW  = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic        ins_valid;
  logic        dm_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_bubble;
  logic        pipe_en;
  logic [1:0]  hazard_state;
  logic [7:0]  stall_cnt;
  logic [7:0]  freeze_cnt;

  pipeline_hazard_controller dut (
    .clk          (clk),
    .reset        (reset),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .dm_ready     (dm_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_bubble  (idex_bubble),
    .pipe_en      (pipe_en),
    .hazard_state (hazard_state),
    .stall_cnt    (stall_cnt),
    .freeze_cnt   (freeze_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       bub;
    logic       pipe;
    logic [1:0] st;
    logic [7:0] sc;
    logic [7:0] fc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   exp_sc = 0;
  int   exp_fc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, req);
    end
  endtask

  localparam logic [31:0] LD4  = {6'b010100, 5'd4, 5'd1, 16'h0};
  localparam logic [31:0] LD6  = {6'b010100, 5'd6, 5'd1, 16'h0};
  localparam logic [31:0] LD0  = {6'b010100, 5'd0, 5'd1, 16'h0};
  localparam logic [31:0] USE4 = {6'b000100, 5'd5, 5'd1, 5'd4, 11'd0};
  localparam logic [31:0] USE6 = {6'b000100, 5'd5, 5'd1, 5'd6, 11'd0};
  localparam logic [31:0] USE0 = {6'b000000, 5'd5, 5'd0, 5'd0, 11'd0};
  localparam logic [31:0] ALU  = {6'b000000, 5'd1, 5'd2, 5'd3, 11'd0};
  localparam logic [31:0] ST6  = {6'b010101, 5'd6, 5'd1, 16'h0};

  // Drive one cycle of stimulus and queue what the DUT must show.
  task automatic cyc(input logic [31:0] i, input logic v,
                     input logic r, input logic [1:0] st);
    exp_t x;
    @(posedge clk);
    #1;
    ins       = i;
    ins_valid = v;
    dm_ready  = r;
    x.st   = st;
    x.pc   = (st == S_RUN);
    x.ifid = (st == S_RUN);
    x.bub  = (st == S_LS);
    x.pipe = (st != S_MW);
    x.sc   = exp_sc[7:0];
    x.fc   = exp_fc[7:0];
    exp_q.push_back(x);
    if (st == S_LS && exp_sc < 255) exp_sc++;
    if (st == S_MW && exp_fc < 255) exp_fc++;
  endtask

  // Pop and compare on the falling edge, away from the update edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_en",  {31'd0, pc_en},       {31'd0, e.pc});
      chk("ifid",   {31'd0, ifid_en},     {31'd0, e.ifid});
      chk("bubble", {31'd0, idex_bubble}, {31'd0, e.bub});
      chk("pipe",   {31'd0, pipe_en},     {31'd0, e.pipe});
      chk("state",  {30'd0, hazard_state}, {30'd0, e.st});
      chk("stall",  {24'd0, stall_cnt},   {24'd0, e.sc});
      chk("freeze", {24'd0, freeze_cnt},  {24'd0, e.fc});
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pc"},     {31'd0, pc_en},       32'd0);
    chk({tag, "_ifid"},   {31'd0, ifid_en},     32'd0);
    chk({tag, "_pipe"},   {31'd0, pipe_en},     32'd0);
    chk({tag, "_bub"},    {31'd0, idex_bubble}, 32'd0);
    chk({tag, "_state"},  {30'd0, hazard_state}, 32'd0);
    chk({tag, "_stall"},  {24'd0, stall_cnt},   32'd0);
    chk({tag, "_freeze"}, {24'd0, freeze_cnt},  32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    ins       = 32'h0;
    ins_valid = 1'b0;
    dm_ready  = 1'b1;
    #3;
    chk_reset_outs("init");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    // load-use on rb
    cyc(LD4,   1'b1, 1'b1, S_RUN);
    cyc(USE4,  1'b1, 1'b1, S_LS);
    cyc(USE4,  1'b1, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    // independent consumer
    cyc(LD4,   1'b1, 1'b1, S_RUN);
    cyc(ALU,   1'b1, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    // R0 never hazards
    cyc(LD0,   1'b1, 1'b1, S_RUN);
    cyc(USE0,  1'b1, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    // load two ahead of its use
    cyc(LD4,   1'b1, 1'b1, S_RUN);
    cyc(ALU,   1'b1, 1'b1, S_RUN);
    cyc(USE4,  1'b1, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    // store data dependency
    cyc(LD6,   1'b1, 1'b1, S_RUN);
    cyc(ST6,   1'b1, 1'b1, S_LS);
    cyc(ST6,   1'b1, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    // memory wait for 3 cycles
    cyc(LD4,   1'b1, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b0, S_MW);
    cyc(32'h0, 1'b0, 1'b0, S_MW);
    cyc(32'h0, 1'b0, 1'b0, S_MW);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    // load-use pending during a wait
    cyc(LD4,   1'b1, 1'b1, S_RUN);
    cyc(LD6,   1'b1, 1'b1, S_RUN);
    cyc(USE6,  1'b1, 1'b0, S_MW);
    cyc(USE6,  1'b1, 1'b0, S_MW);
    cyc(USE6,  1'b1, 1'b1, S_LS);
    cyc(USE6,  1'b1, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    drain();
    chk("stall_total",  {24'd0, stall_cnt},  32'd3);
    chk("freeze_total", {24'd0, freeze_cnt}, 32'd5);

    // asynchronous reset during an active stall
    cyc(LD4,   1'b1, 1'b1, S_RUN);
    cyc(USE4,  1'b1, 1'b1, S_LS);
    drain();
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs("midrst");
    exp_sc = 0;
    exp_fc = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(USE4,  1'b1, 1'b1, S_RUN);
    cyc(32'h0, 1'b0, 1'b1, S_RUN);

    // saturation
    for (int k = 0; k < 300; k++) begin
      cyc(LD4,  1'b1, 1'b1, S_RUN);
      cyc(USE4, 1'b1, 1'b1, S_LS);
    end
    cyc(32'h0, 1'b0, 1'b1, S_RUN);
    drain();
    chk("stall_sat", {24'd0, stall_cnt}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
